retire_free_gen: RTL and testbench

//  Retire-side architectural map table; producer of the freelist's dealloc and restore inputs.
//  Per cycle, commits up to RETIRE_WIDTH retiring destinations in program order.

---
 rtl/retire_free_gen.sv | 76 +++++++
 tb/tb_retire_free_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_free_gen.sv
// Retire-side architectural map: commits up to RETIRE_WIDTH destinations per cycle in program order,
// reports superseded physical registers and the committed free set for freelist dealloc and rollback.
module retire_free_gen #(
    parameter int RETIRE_WIDTH = 3,
    parameter int PR_COUNT     = 64,
    parameter int ARCH_COUNT   = 32,
    localparam int AW          = $clog2(ARCH_COUNT),
    localparam int PW          = $clog2(PR_COUNT)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [RETIRE_WIDTH-1:0]              retire_valid,
    input  logic [RETIRE_WIDTH-1:0]              retire_has_dest,
    input  logic [RETIRE_WIDTH-1:0][AW-1:0]      retire_arch_dest,
    input  logic [RETIRE_WIDTH-1:0][PW-1:0]      retire_phys_dest,
    input  logic                                 retire_mispredict,
    output logic [PR_COUNT-1:0]                  free_mask,
    output logic [PR_COUNT-1:0]                  restore_mask,
    output logic                                 mispredict,
    output logic [ARCH_COUNT-1:0][PW-1:0]        arch_map
);

    logic [ARCH_COUNT-1:0][PW-1:0] map_next_s;
    logic [PR_COUNT-1:0]           free_next_s;
    logic [PR_COUNT-1:0]           busy_next_s;

    // Free set after reset: the identity map occupies phys 0..ARCH_COUNT-1.
    function automatic logic [PR_COUNT-1:0] reset_restore_mask();
        logic [PR_COUNT-1:0] mask_v;
        mask_v = '0;
        for (int i = 0; i < PR_COUNT; i++) begin
            mask_v[i] = (i >= ARCH_COUNT) ? 1'b1 : 1'b0;
        end
        return mask_v;
    endfunction

    // In-order commit walk on a working copy so same-arch lanes chain within the cycle.
    always_comb begin
        map_next_s  = arch_map;
        free_next_s = '0;
        for (int l = 0; l < RETIRE_WIDTH; l++) begin
            if (retire_valid[l] && retire_has_dest[l] && (retire_arch_dest[l] != {AW{1'b0}})) begin
                free_next_s[map_next_s[retire_arch_dest[l]]] = 1'b1;
                map_next_s[retire_arch_dest[l]]              = retire_phys_dest[l];
            end else begin
                free_next_s = free_next_s;
            end
        end
    end

    // Physical registers named by the post-commit map are busy; everything else is free.
    always_comb begin
        busy_next_s = '0;
        for (int i = 0; i < ARCH_COUNT; i++) begin
            busy_next_s[map_next_s[i]] = 1'b1;
        end
    end

    // Register committed map and the freelist-facing strobes; reset drops any in-flight commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_COUNT; i++) begin
                arch_map[i] <= PW'(i);
            end
            free_mask    <= '0;
            restore_mask <= reset_restore_mask();
            mispredict   <= 1'b0;
        end else begin
            arch_map     <= map_next_s;
            free_mask    <= free_next_s;
            restore_mask <= ~busy_next_s;
            mispredict   <= retire_mispredict;
        end
    end

endmodule

// File: tb/tb_retire_free_gen.sv
// Directed and constrained-random checks for retire_free_gen with a small reference map model.
module tb_retire_free_gen;

    localparam int W  = 3;
    localparam int PR = 64;
    localparam int AR = 32;
    localparam int AW = $clog2(AR);
    localparam int PW = $clog2(PR);

    logic                   clock = 1'b0;
    logic                   reset;
    logic [W-1:0]           retire_valid;
    logic [W-1:0]           retire_has_dest;
    logic [W-1:0][AW-1:0]   retire_arch_dest;
    logic [W-1:0][PW-1:0]   retire_phys_dest;
    logic                   retire_mispredict;
    logic [PR-1:0]          free_mask;
    logic [PR-1:0]          restore_mask;
    logic                   mispredict;
    logic [AR-1:0][PW-1:0]  arch_map;

    int n_vec  = 0;
    int n_miss = 0;
    int m_map [AR];

    always #5 clock = ~clock;

    retire_free_gen #(.RETIRE_WIDTH(W), .PR_COUNT(PR), .ARCH_COUNT(AR)) dut (
        .clock            (clock),
        .reset            (reset),
        .retire_valid     (retire_valid),
        .retire_has_dest  (retire_has_dest),
        .retire_arch_dest (retire_arch_dest),
        .retire_phys_dest (retire_phys_dest),
        .retire_mispredict(retire_mispredict),
        .free_mask        (free_mask),
        .restore_mask     (restore_mask),
        .mispredict       (mispredict),
        .arch_map         (arch_map)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_lanes();
        retire_valid      = '0;
        retire_has_dest   = '0;
        retire_arch_dest  = '0;
        retire_phys_dest  = '0;
        retire_mispredict = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic v, input logic hd, input int a, input int p);
        retire_valid[l]     = v;
        retire_has_dest[l]  = hd;
        retire_arch_dest[l] = AW'(a);
        retire_phys_dest[l] = PW'(p);
    endtask

    function automatic bit in_model_map(input int p);
        for (int i = 0; i < AR; i++) begin
            if (m_map[i] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    logic [PR-1:0]      exp_free;
    logic [PR-1:0]      exp_restore;
    logic               exp_mp;
    logic [AR*PW-1:0]   exp_map_vec;
    logic [PR-1:0]      used;
    logic [PR-1:0]      seen;
    logic               dup;
    int                 nv;
    int                 p;
    int                 tries;

    initial begin
        clear_lanes();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();

        // 1: reset state
        for (int i = 0; i < AR; i++) check("rst_map", 256'(arch_map[i]), 256'(i));
        check("rst_free", 256'(free_mask), 256'd0);
        check("rst_mispredict", 256'(mispredict), 256'd0);
        check("rst_restore", 256'(restore_mask), 256'(64'hFFFF_FFFF_0000_0000));

        // 2: single commit arch5 -> phys40
        set_lane(0, 1'b1, 1'b1, 5, 40);
        step();
        clear_lanes();
        check("t2_free", 256'(free_mask), 256'(64'd1 << 5));
        check("t2_map5", 256'(arch_map[5]), 256'd40);
        check("t2_restore40", 256'(restore_mask[40]), 256'd0);
        check("t2_restore5", 256'(restore_mask[5]), 256'd1);
        step();
        check("t2_free_clear", 256'(free_mask), 256'd0);

        // 3: same arch in two lanes chains the free
        set_lane(0, 1'b1, 1'b1, 7, 41);
        set_lane(1, 1'b1, 1'b1, 7, 42);
        step();
        clear_lanes();
        check("t3_free", 256'(free_mask), 256'((64'd1 << 7) | (64'd1 << 41)));
        check("t3_map7", 256'(arch_map[7]), 256'd42);
        check("t3_restore41", 256'(restore_mask[41]), 256'd1);

        // 4: arch0 write ignored, no-dest lane ignored
        set_lane(0, 1'b1, 1'b1, 0, 43);
        set_lane(1, 1'b1, 1'b0, 3, 45);
        step();
        clear_lanes();
        check("t4_free", 256'(free_mask), 256'd0);
        check("t4_map0", 256'(arch_map[0]), 256'd0);
        check("t4_map3", 256'(arch_map[3]), 256'd3);
        check("t4_restore43", 256'(restore_mask[43]), 256'd1);

        // 5: commit plus mispredicted branch in the last valid lane
        set_lane(0, 1'b1, 1'b1, 9, 44);
        set_lane(1, 1'b1, 1'b0, 0, 0);
        retire_mispredict = 1'b1;
        step();
        clear_lanes();
        check("t5_mispredict", 256'(mispredict), 256'd1);
        check("t5_free", 256'(free_mask), 256'(64'd1 << 9));
        check("t5_restore44", 256'(restore_mask[44]), 256'd0);
        check("t5_popcount", 256'($countones(restore_mask)), 256'(PR - AR));
        step();
        check("t5_mispredict_clear", 256'(mispredict), 256'd0);

        // 6: random full-width retire against the reference model, reset mid-stream
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < AR; i++) m_map[i] = i;
        for (int c = 0; c < 1000; c++) begin
            clear_lanes();
            reset = (c == 500 || c == 501) ? 1'b1 : 1'b0;
            nv = $urandom_range(0, W);
            used = '0;
            for (int l = 0; l < nv; l++) begin
                tries = 0;
                p = $urandom_range(0, PR - 1);
                while ((in_model_map(p) || used[p]) && tries < 500) begin
                    p = $urandom_range(0, PR - 1);
                    tries++;
                end
                used[p] = 1'b1;
                set_lane(l, 1'b1, 1'($urandom_range(0, 3) != 0), $urandom_range(0, AR - 1), p);
            end
            retire_mispredict = (nv > 0) ? 1'($urandom_range(0, 7) == 0) : 1'b0;

            exp_free = '0;
            if (reset) begin
                for (int i = 0; i < AR; i++) m_map[i] = i;
                exp_mp = 1'b0;
            end else begin
                for (int l = 0; l < W; l++) begin
                    if (retire_valid[l] && retire_has_dest[l] && retire_arch_dest[l] != 0) begin
                        exp_free[m_map[retire_arch_dest[l]]] = 1'b1;
                        m_map[retire_arch_dest[l]] = int'(retire_phys_dest[l]);
                    end
                end
                exp_mp = retire_mispredict;
            end
            exp_restore = '1;
            for (int i = 0; i < AR; i++) begin
                exp_restore[m_map[i]] = 1'b0;
                exp_map_vec[i*PW +: PW] = PW'(m_map[i]);
            end

            step();
            check("rnd_map", 256'(arch_map), 256'(exp_map_vec));
            check("rnd_free", 256'(free_mask), 256'(exp_free));
            check("rnd_restore", 256'(restore_mask), 256'(exp_restore));
            check("rnd_mispredict", 256'(mispredict), 256'(exp_mp));
            check("inv_popcount", 256'($countones(restore_mask)), 256'(PR - AR));
            check("inv_free_in_restore", 256'(free_mask & ~restore_mask), 256'd0);
            seen = '0;
            dup  = 1'b0;
            for (int i = 0; i < AR; i++) begin
                if (seen[arch_map[i]]) dup = 1'b1;
                seen[arch_map[i]] = 1'b1;
            end
            check("inv_distinct", 256'(dup), 256'd0);
        end

        // After the stream, a reset must restore identity and reset masks.
        clear_lanes();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < AR; i++) check("end_rst_map", 256'(arch_map[i]), 256'(i));
        check("end_rst_free", 256'(free_mask), 256'd0);
        check("end_rst_restore", 256'(restore_mask), 256'(64'hFFFF_FFFF_0000_0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
